if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline. Sits between the PC/instruction memory (IM) and the IF/ID register feeding decode.
- Holds the PC and issues word reads to the synchronous-read IM, which has 1-cycle latency.
- Buffers returned instructions in a 2-entry skid queue so decode stalls never lose a fetch.
- Accepts branch/jump redirects, which flush all wrong-path work.

Parameters:
- RESET_PC, 32'h0000_3000, byte PC after reset. Corresponds to IM word index 0x0C00.
- IM_AW, 15, IM word-address width. im_128k holds 32K words.

Ports:
- Clk, input, 1, pipeline clock. All state updates on the rising edge.
- Rst, input, 1, asynchronous, active-high reset.
- im_req, output, 1, IM read enable this cycle.
- im_addr, output, IM_AW, word address, equal to PC[IM_AW+1:2].
- im_rdata, input, 32, IM data for the request issued in the previous cycle.
- redirect_valid, input, 1, branch/jump taken; flush and restart fetch.
- redirect_pc, input, 32, target byte address.
- id_ready, input, 1, decode accepts the head instruction this cycle.
- if_valid, output, 1, if_instr/if_pc/if_pc4 are valid.
- if_instr, output, 32, fetched instruction.
- if_pc, output, 32, byte address of if_instr.
- if_pc4, output, 32, if_pc + 4 (mod 2^32).

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC.
  - Queue empty; in-flight flag cleared.
  - Outputs: im_req = 0, im_addr = 0, if_valid = 0, if_instr = 0, if_pc = 0, if_pc4 = 0.
- Reset mid-operation: discards queued and in-flight fetches with no partial output. Fetch restarts at RESET_PC.
- Occupancy: occ = queue entries + in-flight (0 or 1). Invariant occ ≤ 2.
- Pop: occurs when if_valid && id_ready && !redirect_valid.
- Issue rule:
  - im_req = 1 when !Rst && !redirect_valid && (occ − pop) < 2.
  - On issue, the request is tagged with the current PC, and PC ← PC + 4 (32-bit wrap: 0xFFFF_FFFC → 0).
  - im_addr is driven combinationally from PC.
- Response: the cycle after an issue, im_rdata is enqueued with its tagged PC, unless the in-flight request was squashed.
- Queue:
  - Two-entry FIFO. Head drives if_instr/if_pc/if_pc4; if_valid = queue non-empty.
  - Outputs are registered from queue storage, so there is no combinational path from im_rdata to if_instr.
  - Push and pop in the same cycle are legal when full or empty-plus-bypass-free. Entry count is unchanged and order is preserved.
- Latency: the first edge with Rst low issues RESET_PC. The instruction is enqueued on the next edge, so if_valid rises 2 edges after reset release. Steady state is 1 instruction/cycle with id_ready held high.
- Stall: with id_ready = 0 the queue fills to 2, then im_req = 0. Head outputs are held stable. No instruction is dropped or duplicated.
- Redirect (highest priority):
  - In the cycle redirect_valid = 1: queue cleared, in-flight response marked squashed, PC ← redirect_pc, no pop, im_req = 0.
  - Next edge: issue from redirect_pc. Edge after that: if_valid = 1 with if_pc = redirect_pc.
  - Back-to-back redirects: the last one wins.
  - redirect_pc[1:0] is ignored (forced 00) unless IF_EXC_EN.
- Simultaneous events:
  - Redirect + id_ready: the pop is suppressed, since the flushed head was never consumed by decode.
  - Redirect + Rst: Rst wins.
- Address truncation: PC bits above IM_AW+1 are ignored for im_addr. Aliasing is permitted.

Optional Feature:
- Macro: IF_EXC_EN.
- When defined, adds output if_exc (1 bit, reset 0), an instruction-fetch address-error flag.
- A redirect_pc with bits [1:0] ≠ 0 does not issue to IM. Instead it enqueues one entry with if_instr = 32'h0000_0000 (NOP), if_pc = redirect_pc as given, and if_exc = 1.
- Fetch then stalls (no issue) until the next redirect or reset.
- When undefined: no if_exc port, and bits [1:0] are silently cleared.

Decomposition:
- Shared package mips_pkg: RESET_PC default, NOP_INSTR = 32'h0, INSTR_W = 32, PC_W = 32.
- One sub-module, if_fifo2: 2-entry FIFO with push/pop/flush, carrying the {pc, instr[, exc]} payload, exposing empty/count.

Test Plan:
1. Reset and stream: IM[0x0C00..0x0C03] = 0x20080001..04, id_ready = 1. Release Rst. → if_valid rises at edge 2. if_pc = 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles with matching instr.
2. Stall: id_ready = 0 for 5 cycles mid-stream. → At most 2 entries buffered; im_req = 0 after the queue fills; head held at 0x3008. On resume, 0x3008, 0x300C, 0x3010 appear in order with no gaps or duplicates.
3. Redirect flush: redirect_valid = 1 with redirect_pc = 0x3040 while 2 entries are queued and 1 is in flight. → Next cycle if_valid = 0. Two edges later if_pc = 0x3040, and no 0x30xx wrong-path PC is emitted.
4. Redirect with id_ready = 1 in the same cycle: → The head is not counted as popped; the first valid after the flush is the target.
5. Async reset mid-stall (Rst pulsed between edges): → Outputs go to 0 immediately. The stream restarts at 0x3000.
6. PC wrap: redirect to 0xFFFF_FFFC. → if_pc = 0xFFFF_FFFC with if_pc4 = 0, followed by if_pc = 0x0000_0000. With IF_EXC_EN, also redirect to 0x3042 → single entry with if_exc = 1, if_instr = 0, and no im_req until the next redirect.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline front end.
//   RESET_PC_DEFAULT - byte PC after reset (IM word index 0x0C00)
//   NOP_INSTR        - all-zero instruction (sll $0,$0,0)
//   INSTR_W / PC_W   - instruction and program-counter widths
//   fetch_entry_t    - payload carried through the fetch queue; gains an
//                      address-error bit when IF_EXC_EN is defined
//   pc_next()        - sequential PC increment, wraps modulo 2^32
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
`ifdef IF_EXC_EN
        logic               exc;
`endif
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: bundle of the fetch stage's instruction-memory,
// redirect and decode-side signals.
//   master - the fetch stage (drives im_req/im_addr and the if_* outputs)
//   slave  - the environment (IM, branch unit, decode)
// With IF_EXC_EN defined the bundle also carries if_exc.
interface if_fetch_stage_if #(
    parameter int IM_AW = 15
) ();
    import mips_pkg::*;

    logic               im_req;
    logic [IM_AW-1:0]   im_addr;
    logic [INSTR_W-1:0] im_rdata;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               id_ready;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic [PC_W-1:0]    if_pc4;

`ifdef IF_EXC_EN
    logic               if_exc;

    modport master (
        output im_req, im_addr, if_valid, if_instr, if_pc, if_pc4, if_exc,
        input  im_rdata, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  im_req, im_addr, if_valid, if_instr, if_pc, if_pc4, if_exc,
        output im_rdata, redirect_valid, redirect_pc, id_ready
    );
`else
    modport master (
        output im_req, im_addr, if_valid, if_instr, if_pc, if_pc4,
        input  im_rdata, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  im_req, im_addr, if_valid, if_instr, if_pc, if_pc4,
        output im_rdata, redirect_valid, redirect_pc, id_ready
    );
`endif

endinterface

// File: rtl/if_fifo2.sv
// if_fifo2: two-entry FIFO for fetched instructions.
//   clk, rst  - clock, asynchronous active-high reset (clears count only)
//   flush     - drop all entries; a simultaneous push lands in the empty queue
//   push      - write push_data
//   pop       - retire the head (caller guarantees non-empty)
//   head      - oldest entry, read straight from storage registers
//   empty     - no entries
//   count     - number of entries (0..2)
// Slot 0 always holds the head, so the head is a plain register with no
// read-pointer mux in front of it.
module if_fifo2
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic [1:0]   count
);

    fetch_entry_t slot0_p1;
    fetch_entry_t slot1_p1;
    logic [1:0]   count_nxt;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = {1'b0, push};
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 2'd1;
                2'b01:   count_nxt = count - 2'd1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
        end else begin
            count <= count_nxt;
        end
    end

    // ---- storage stage: shift toward slot 0 on pop ----
    always_ff @(posedge clk) begin
        if (flush) begin
            if (push) slot0_p1 <= push_data;
        end else if (pop) begin
            if (count == 2'd2) begin
                slot0_p1 <= slot1_p1;
                if (push) slot1_p1 <= push_data;
            end else if (push) begin
                slot0_p1 <= push_data;
            end
        end else if (push) begin
            if (count == 2'd0) slot0_p1 <= push_data;
            else               slot1_p1 <= push_data;
        end
    end

    assign head  = slot0_p1;
    assign empty = (count == 2'd0);

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch front end of the 5-stage MIPS pipeline.
//   clk  - pipeline clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - if_fetch_stage_if.master:
//          im_req/im_addr/im_rdata        synchronous IM, 1-cycle latency
//          redirect_valid/redirect_pc     branch/jump redirect, flushes work
//          id_ready                       decode accepts the head this cycle
//          if_valid/if_instr/if_pc/if_pc4 head of the fetch queue
// Parameters: RESET_PC (byte PC after reset), IM_AW (IM word-address width).
// Optional macro IF_EXC_EN: a misaligned redirect target enqueues a single
// NOP with if_exc = 1 and halts fetch until the next redirect or reset.
// Without it, redirect_pc[1:0] is cleared.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              IM_AW    = 15
) (
    input logic              clk,
    input logic              rst,
    if_fetch_stage_if.master bus
);

    logic [PC_W-1:0] pc_p0;
    logic [PC_W-1:0] pc_p1;
    logic [PC_W-1:0] redir_pc;
    logic            vld_p1;
    logic            redir;
    logic            pop;
    logic            issue;
    logic            fetch_push;
    logic            fifo_push;
    logic            fifo_empty;
    logic [1:0]      fifo_count;
    logic [1:0]      occ;
    fetch_entry_t    fifo_in;
    fetch_entry_t    head;

    assign redir = bus.redirect_valid;
    // A redirect flushes the head, so decode never consumed it.
    assign pop   = !fifo_empty && bus.id_ready && !redir;
    // Queue entries plus the one response that may be in flight.
    assign occ   = fifo_count + {1'b0, vld_p1};
    // A response arriving in a redirect cycle is wrong-path: drop it.
    assign fetch_push = vld_p1 && !redir;

`ifdef IF_EXC_EN
    logic halt;
    logic redir_misaligned;

    assign redir_misaligned = redir && (bus.redirect_pc[1:0] != 2'b00);
    assign redir_pc  = bus.redirect_pc;
    // rst is kept out of issue so the flops below never see it on their D path.
    assign issue     = !redir && !halt && ((occ - {1'b0, pop}) < 2'd2);
    assign fifo_push = fetch_push || redir_misaligned;

    always_comb begin
        fifo_in.pc    = pc_p1;
        fifo_in.instr = bus.im_rdata;
        fifo_in.exc   = 1'b0;
        if (redir_misaligned) begin
            fifo_in.pc    = bus.redirect_pc;
            fifo_in.instr = NOP_INSTR;
            fifo_in.exc   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt <= 1'b0;
        end else if (redir) begin
            halt <= redir_misaligned;
        end
    end

    assign bus.if_exc = !fifo_empty && head.exc;
`else
    assign redir_pc  = bus.redirect_pc & ~32'h0000_0003;
    assign issue     = !redir && ((occ - {1'b0, pop}) < 2'd2);
    assign fifo_push = fetch_push;

    always_comb begin
        fifo_in.pc    = pc_p1;
        fifo_in.instr = bus.im_rdata;
    end
`endif

    // ---- p0: PC / issue stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (redir) begin
                pc_p0 <= redir_pc;
            end else if (issue) begin
                pc_p0 <= pc_next(pc_p0);
            end
        end
    end

    // ---- p1: IM access in flight, tag travels with it ----
    always_ff @(posedge clk) begin
        if (issue) pc_p1 <= pc_p0;
    end

    if_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.im_req   = issue && !rst;
    assign bus.im_addr  = rst ? '0 : pc_p0[IM_AW+1:2];
    assign bus.if_valid = !fifo_empty;
    // Payload outputs read zero whenever the queue is empty (including reset).
    assign bus.if_instr = fifo_empty ? NOP_INSTR : head.instr;
    assign bus.if_pc    = fifo_empty ? '0 : head.pc;
    assign bus.if_pc4   = fifo_empty ? '0 : pc_next(head.pc);

endmodule
